// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the clock-branch gating controller.
// State encoding, default settling/idle times and the wake counter width.
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } cg_state_e;

  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_IDLE_CYCLES = 8;
  localparam int WAKE_CNT_W      = 16;

endpackage

// File: rtl/cg_timer.sv
// Loadable down-counter shared by the wake-up settling and idle-timeout phases.
// Load takes priority over decrement; the count never wraps below zero.
module cg_timer #(
  parameter int W = 4
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: load, decrement or hold.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/clk_gate_ctrl.sv
// Sequences the enable of a gated clock branch for NUM_REQ requesters:
// wake-up settling before grants, idle hold-off before gating off.
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  force_on,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  clk_en,
  output logic                  clk_on,
  output logic [WAKE_CNT_W-1:0] wake_cnt
);

  localparam int MAX_CYC = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0]         WAKE_LOAD    = TW'(WAKE_CYCLES - 1);
  localparam logic [TW-1:0]         IDLE_LOAD    = TW'(IDLE_CYCLES - 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_CNT_MAX = {WAKE_CNT_W{1'b1}};

  cg_state_e             state_r, state_s;
  logic [NUM_REQ-1:0]    ack_r, ack_s;
  logic                  clk_en_r, clk_on_r;
  logic [WAKE_CNT_W-1:0] wake_cnt_r;
  logic                  any_s, tmr_load_s, tmr_dec_s, tmr_zero_s, wake_inc_s;
  logic [TW-1:0]         tmr_val_s;

  assign any_s = (|req) | force_on;

  cg_timer #(.W(TW)) u_timer (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .dec      (tmr_dec_s),
    .zero     (tmr_zero_s)
  );

  // Next-state, timer control and grant decode.
  always_comb begin
    state_s    = state_r;
    tmr_load_s = 1'b0;
    tmr_val_s  = {TW{1'b0}};
    tmr_dec_s  = 1'b0;
    wake_inc_s = 1'b0;
    case (state_r)
      ST_OFF: begin
        if (any_s) begin
          state_s    = ST_WAKE;
          tmr_load_s = 1'b1;
          tmr_val_s  = WAKE_LOAD;
          wake_inc_s = 1'b1;
        end else begin
          state_s = ST_OFF;
        end
      end
      // Settling is never aborted; a vanished request is handled from ON.
      ST_WAKE: begin
        if (tmr_zero_s) begin
          state_s = ST_ON;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      ST_ON: begin
        if (!any_s) begin
          state_s    = ST_IDLE;
          tmr_load_s = 1'b1;
          tmr_val_s  = IDLE_LOAD;
        end else begin
          state_s = ST_ON;
        end
      end
      // A returning request beats a simultaneous timeout.
      ST_IDLE: begin
        if (any_s) begin
          state_s = ST_ON;
        end else if (tmr_zero_s) begin
          state_s = ST_OFF;
        end else begin
          tmr_dec_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_OFF;
      end
    endcase
    ack_s = (state_r == ST_ON) ? req : {NUM_REQ{1'b0}};
  end

  // State and registered outputs; clk_en only moves on the rising edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_OFF;
      ack_r    <= {NUM_REQ{1'b0}};
      clk_en_r <= 1'b0;
      clk_on_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      ack_r    <= ack_s;
      clk_en_r <= (state_s != ST_OFF);
      clk_on_r <= (state_s == ST_ON);
    end
  end

  // Saturating count of wake-ups.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wake_cnt_r <= {WAKE_CNT_W{1'b0}};
    end else if (wake_inc_s && (wake_cnt_r != WAKE_CNT_MAX)) begin
      wake_cnt_r <= wake_cnt_r + {{(WAKE_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wake_cnt_r <= wake_cnt_r;
    end
  end

  assign ack      = ack_r;
  assign clk_en   = clk_en_r;
  assign clk_on   = clk_on_r;
  assign wake_cnt = wake_cnt_r;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with default parameters: a vector table
// for wake/release/gate-off, then hand sequences for the multi-cycle corners.
module tb_clk_gate_ctrl;

  logic        clk_in;
  logic        rst_n;
  logic [3:0]  req;
  logic        force_on;
  logic [3:0]  ack;
  logic        clk_en;
  logic        clk_on;
  logic [15:0] wake_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  clk_gate_ctrl #(.NUM_REQ(4), .WAKE_CYCLES(2), .IDLE_CYCLES(8)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .req      (req),
    .force_on (force_on),
    .ack      (ack),
    .clk_en   (clk_en),
    .clk_on   (clk_on),
    .wake_cnt (wake_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  req;
    logic        force_on;
    logic [3:0]  ack;
    logic        en;
    logic        on;
    logic [15:0] wc;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  function automatic vec_t mk(logic [3:0] r, logic f, logic [3:0] a, logic e, logic o, logic [15:0] w);
    vec_t v;
    v.req = r; v.force_on = f; v.ack = a; v.en = e; v.on = o; v.wc = w;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Steps until clk_en falls (bounded) and checks how many edges it took.
  task automatic wait_off(input int exp_edges);
    int n;
    n = 0;
    while (clk_en && n < 20) begin
      step();
      n++;
    end
    check("gate_off_edges", n, exp_edges);
    check("gate_off_on", {31'd0, clk_on}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_en"},  {31'd0, clk_en}, 32'd0);
    check({tag, "_on"},  {31'd0, clk_on}, 32'd0);
    check({tag, "_ack"}, {28'd0, ack},    32'd0);
    check({tag, "_wc"},  {16'd0, wake_cnt}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Wake with req[0], add/drop req[1] while ON, release, then idle timeout.
    vecs[0]  = mk(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 16'd1);
    vecs[1]  = mk(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 16'd1);
    vecs[2]  = mk(4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 16'd1);
    vecs[3]  = mk(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 16'd1);
    vecs[4]  = mk(4'b0011, 1'b0, 4'b0011, 1'b1, 1'b1, 16'd1);
    vecs[5]  = mk(4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 16'd1);
    vecs[6]  = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 16'd1);
    for (int i = 7; i < 14; i++) vecs[i] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 16'd1);
    vecs[14] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd1);

    req = 4'b0000; force_on = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      req = vecs[i].req;
      force_on = vecs[i].force_on;
      step();
      check($sformatf("v%0d_ack", i), {28'd0, ack}, {28'd0, vecs[i].ack});
      check($sformatf("v%0d_en", i),  {31'd0, clk_en}, {31'd0, vecs[i].en});
      check($sformatf("v%0d_on", i),  {31'd0, clk_on}, {31'd0, vecs[i].on});
      check($sformatf("v%0d_wc", i),  {16'd0, wake_cnt}, {16'd0, vecs[i].wc});
    end

    // Request returns in IDLE at timer 3: back to ON without gating.
    req = 4'b0001;
    repeat (3) step();
    check("a_on", {31'd0, clk_on}, 32'd1);
    check("a_wc", {16'd0, wake_cnt}, 32'd2);
    req = 4'b0000;
    step();
    check("a_idle_on", {31'd0, clk_on}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("a_idle_en", {31'd0, clk_en}, 32'd1);
    end
    req = 4'b0100;
    step();
    check("a_reon_on", {31'd0, clk_on}, 32'd1);
    check("a_reon_en", {31'd0, clk_en}, 32'd1);
    check("a_reon_ack", {28'd0, ack}, 32'd0);
    step();
    check("a_ack2", {28'd0, ack}, 32'h4);
    check("a_wc_same", {16'd0, wake_cnt}, 32'd2);
    req = 4'b0000;
    step();
    check("a_drop_ack", {28'd0, ack}, 32'd0);
    wait_off(8);

    // Requests swap during WAKE: grant follows what is present at ON.
    req = 4'b0001;
    step();
    check("b_wc", {16'd0, wake_cnt}, 32'd3);
    req = 4'b1000;
    step();
    step();
    check("b_on", {31'd0, clk_on}, 32'd1);
    check("b_ack0", {28'd0, ack}, 32'd0);
    step();
    check("b_ack", {28'd0, ack}, 32'h8);
    req = 4'b0000;
    step();
    wait_off(8);

    // All requests vanish during WAKE: ON for one cycle, then IDLE.
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    step();
    check("b2_on", {31'd0, clk_on}, 32'd1);
    step();
    check("b2_idle_on", {31'd0, clk_on}, 32'd0);
    check("b2_idle_en", {31'd0, clk_en}, 32'd1);
    check("b2_ack", {28'd0, ack}, 32'd0);
    wait_off(8);
    check("b2_wc", {16'd0, wake_cnt}, 32'd4);

    // force_on alone holds ON with no grants.
    force_on = 1'b1;
    step();
    check("c_wc", {16'd0, wake_cnt}, 32'd5);
    step();
    step();
    for (int i = 0; i < 20; i++) begin
      check("c_hold_on", {31'd0, clk_on}, 32'd1);
      check("c_hold_ack", {28'd0, ack}, 32'd0);
      step();
    end
    force_on = 1'b0;
    step();
    check("c_idle_on", {31'd0, clk_on}, 32'd0);
    check("c_idle_en", {31'd0, clk_en}, 32'd1);
    wait_off(8);

    // Asynchronous reset mid-IDLE.
    req = 4'b0001;
    repeat (4) step();
    req = 4'b0000;
    step();
    repeat (3) step();
    check("d_pre_en", {31'd0, clk_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_idle");
    #1;
    rst_n = 1'b1;

    // First evaluation after release, then reset mid-WAKE.
    req = 4'b0001;
    step();
    check("d_wake_en", {31'd0, clk_en}, 32'd1);
    check("d_wake_wc", {16'd0, wake_cnt}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_wake");
    #1;
    rst_n = 1'b1;

    // Reset while granting clears ack immediately.
    repeat (4) step();
    check("d_on_ack", {28'd0, ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_on");
    req = 4'b0000;
    #1;
    rst_n = 1'b1;
    step();

    // Saturation: preload the counter just below its ceiling.
    force dut.wake_cnt_r = 16'hFFFE;
    #1;
    release dut.wake_cnt_r;
    req = 4'b0001;
    step();
    check("e_wc_max", {16'd0, wake_cnt}, 32'hFFFF);
    step();
    step();
    req = 4'b0000;
    step();
    wait_off(8);
    req = 4'b0001;
    step();
    check("e_wc_sat", {16'd0, wake_cnt}, 32'hFFFF);
    check("e_en", {31'd0, clk_en}, 32'd1);
    req = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
